// File: rtl/matrix_row_writer_pkg.sv
// matrix_row_writer_pkg: parser state encoding and default geometry/framing constants
package matrix_row_writer_pkg;
  typedef enum logic [2:0] {S_MAGIC, S_ROW, S_R, S_G, S_B, S_DROP} state_t;
  localparam int COLS_DEF = 64;
  localparam int ROWS_DEF = 32;
  localparam logic [7:0] MAGIC_DEF = 8'hA5;
  localparam int RGB_W = 24;
endpackage

// File: rtl/matrix_row_writer.sv
// matrix_row_writer: parses MAGIC,row,COLS*{R,G,B} byte packets into framebuffer pixel writes with row/frame done pulses and a saturating reject count
module matrix_row_writer
  import matrix_row_writer_pkg::*;
#(
  parameter int COLS = COLS_DEF,
  parameter int ROWS = ROWS_DEF,
  parameter logic [7:0] MAGIC = MAGIC_DEF,
  localparam int ADDR_WIDTH = $clog2(ROWS * COLS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic                  s_axis_tlast,
  input  logic                  s_axis_tuser,
  output logic                  fb_wr_en,
  output logic [ADDR_WIDTH-1:0] fb_wr_addr,
  output logic [RGB_W-1:0]      fb_wr_data,
  input  logic                  fb_wr_ready,
  output logic                  row_done,
  output logic                  frame_done,
  output logic [15:0]           err_count
);
  localparam int RW = $clog2(ROWS);
  localparam int CW = $clog2(COLS);
  state_t state;
  logic [RW-1:0] row;
  logic [CW-1:0] col;
  logic [7:0] r, g;
  logic accept, last_col, row_bad, err_inc, good_end;
  assign s_axis_tready = !rst && (!fb_wr_en || fb_wr_ready);
  assign accept = s_axis_tvalid && s_axis_tready;
  assign last_col = col == CW'(COLS - 1);
  assign row_bad = 32'(s_axis_tdata) >= ROWS;
  assign good_end = accept && state == S_B && last_col && s_axis_tlast && !s_axis_tuser;
  assign err_inc = accept && (
    (state == S_MAGIC && (s_axis_tdata != MAGIC || s_axis_tlast)) ||
    (state == S_ROW && (row_bad || s_axis_tlast)) ||
    ((state == S_R || state == S_G) && s_axis_tlast) ||
    (state == S_B && (last_col ? (!s_axis_tlast || s_axis_tuser) : s_axis_tlast)));
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_MAGIC;
      row        <= '0;
      col        <= '0;
      r          <= '0;
      g          <= '0;
      fb_wr_en   <= 1'b0;
      fb_wr_addr <= '0;
      fb_wr_data <= '0;
      row_done   <= 1'b0;
      frame_done <= 1'b0;
      err_count  <= '0;
    end else begin
      row_done   <= good_end;
      frame_done <= good_end && row == RW'(ROWS - 1);
      if (err_inc && err_count != 16'hFFFF) err_count <= err_count + 16'd1;
      if (fb_wr_en && fb_wr_ready) fb_wr_en <= 1'b0;
      if (accept) begin
        case (state)
          S_MAGIC: state <= (s_axis_tdata == MAGIC && !s_axis_tlast) ? S_ROW : s_axis_tlast ? S_MAGIC : S_DROP;
          S_ROW: begin
            row   <= s_axis_tdata[RW-1:0];
            col   <= '0;
            state <= s_axis_tlast ? S_MAGIC : row_bad ? S_DROP : S_R;
          end
          S_R: begin
            r     <= s_axis_tdata;
            state <= s_axis_tlast ? S_MAGIC : S_G;
          end
          S_G: begin
            g     <= s_axis_tdata;
            state <= s_axis_tlast ? S_MAGIC : S_B;
          end
          S_B: begin
            fb_wr_en   <= 1'b1;
            fb_wr_addr <= ADDR_WIDTH'(row) * ADDR_WIDTH'(COLS) + ADDR_WIDTH'(col);
            fb_wr_data <= {r, g, s_axis_tdata};
            col        <= col + CW'(1);
            state      <= s_axis_tlast ? S_MAGIC : last_col ? S_DROP : S_R;
          end
          S_DROP: state <= s_axis_tlast ? S_MAGIC : S_DROP;
          default: state <= S_MAGIC;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_matrix_row_writer.sv
// tb_matrix_row_writer: randomized scoreboard bench with packet-level reference model
module tb_matrix_row_writer;
  localparam int COLS = 64;
  localparam int ROWS = 32;
  localparam int AW = $clog2(ROWS * COLS);
  localparam logic [7:0] MAGIC = 8'hA5;
  logic clk = 0, rst = 1;
  logic [7:0] s_axis_tdata = 0;
  logic s_axis_tvalid = 0, s_axis_tlast = 0, s_axis_tuser = 0, s_axis_tready;
  logic fb_wr_en, fb_wr_ready = 1, row_done, frame_done;
  logic [AW-1:0] fb_wr_addr;
  logic [23:0] fb_wr_data;
  logic [15:0] err_count;
  int errors = 0, checks = 0;
  int cyc = 0, stall_at = -100;
  bit rmode = 0;
  logic [7:0] pkt[$];
  logic [AW+23:0] exp_wr[$];
  bit exp_done[$];
  logic [15:0] exp_err = 0;
  logic held = 0;
  logic [AW+23:0] held_val;

  matrix_row_writer dut (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .s_axis_tlast(s_axis_tlast), .s_axis_tuser(s_axis_tuser),
    .fb_wr_en(fb_wr_en), .fb_wr_addr(fb_wr_addr), .fb_wr_data(fb_wr_data), .fb_wr_ready(fb_wr_ready),
    .row_done(row_done), .frame_done(frame_done), .err_count(err_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    #1 fb_wr_ready = !(cyc >= stall_at && cyc < stall_at + 5) && (rmode ? $urandom_range(3) != 0 : 1'b1);
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, want);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      chk("tready", 64'(s_axis_tready), 64'(!fb_wr_en || fb_wr_ready));
      if (held) begin
        chk("held_en", 64'(fb_wr_en), 64'd1);
        chk("held_addr_data", 64'({fb_wr_addr, fb_wr_data}), 64'(held_val));
      end
      held = fb_wr_en && !fb_wr_ready;
      held_val = {fb_wr_addr, fb_wr_data};
      if (fb_wr_en && fb_wr_ready) begin
        if (exp_wr.size() == 0) chk("unexpected_write", 64'({fb_wr_addr, fb_wr_data}), 64'hDEAD);
        else chk("write", 64'({fb_wr_addr, fb_wr_data}), 64'(exp_wr.pop_front()));
      end
      if (row_done) begin
        if (exp_done.size() == 0) chk("unexpected_row_done", 64'(row_done), 64'd0);
        else chk("frame_done", 64'(frame_done), 64'(exp_done.pop_front()));
      end else if (frame_done) chk("frame_without_row", 64'(frame_done), 64'd0);
    end else held = 0;
  end

  task automatic bump();
    if (exp_err != 16'hFFFF) exp_err++;
  endtask

  task automatic model(input bit tu);
    int n, nw;
    n = pkt.size();
    if (n < 2 || pkt[0] != MAGIC || int'(pkt[1]) >= ROWS) begin
      bump();
      return;
    end
    nw = (n - 2) / 3;
    if (nw > COLS) nw = COLS;
    for (int k = 0; k < nw; k++)
      exp_wr.push_back({AW'(int'(pkt[1]) * COLS + k), pkt[2+3*k], pkt[3+3*k], pkt[4+3*k]});
    if (n == 2 + 3 * COLS && !tu) exp_done.push_back(int'(pkt[1]) == ROWS - 1);
    else bump();
  endtask

  task automatic build(input logic [7:0] first, input logic [7:0] rw, input int npix, input int extra, input bit fixed);
    pkt.delete();
    pkt.push_back(first);
    pkt.push_back(rw);
    for (int i = 0; i < npix; i++) begin
      if (fixed) begin
        pkt.push_back(8'h11); pkt.push_back(8'h22); pkt.push_back(8'h33);
      end else begin
        pkt.push_back(8'($urandom)); pkt.push_back(8'($urandom)); pkt.push_back(8'($urandom));
      end
    end
    for (int i = 0; i < extra; i++) pkt.push_back(8'($urandom));
  endtask

  task automatic wait_accept();
    int t = 0;
    forever begin
      @(negedge clk);
      if (s_axis_tready) break;
      if (++t > 1000) begin
        chk("accept_timeout", 64'(t), 64'd0);
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send_pkt(input bit tu, input bit gaps, input bit with_last);
    for (int i = 0; i < pkt.size(); i++) begin
      if (gaps && $urandom_range(3) == 0) begin
        s_axis_tvalid = 0;
        @(posedge clk);
        #1;
      end
      s_axis_tdata = pkt[i];
      s_axis_tvalid = 1;
      s_axis_tlast = with_last && i == pkt.size() - 1;
      s_axis_tuser = s_axis_tlast ? tu : 1'($urandom);
      wait_accept();
    end
    s_axis_tvalid = 0;
    s_axis_tlast = 0;
    s_axis_tuser = 0;
  endtask

  task automatic run(input bit tu, input bit gaps, input string name);
    model(tu);
    send_pkt(tu, gaps, 1);
    chk(name, 64'(err_count), 64'(exp_err));
  endtask

  task automatic drain();
    int t = 0;
    while (exp_wr.size() != 0 && t < 2000) begin
      @(posedge clk);
      t++;
    end
    repeat (3) @(posedge clk);
    #1;
    chk("drain_writes", 64'(exp_wr.size()), 64'd0);
    chk("drain_done", 64'(exp_done.size()), 64'd0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_tready", 64'(s_axis_tready), 64'd0);
    chk("rst_wr_en", 64'(fb_wr_en), 64'd0);
    chk("rst_addr_data", 64'({fb_wr_addr, fb_wr_data}), 64'd0);
    chk("rst_done", 64'({row_done, frame_done}), 64'd0);
    chk("rst_err", 64'(err_count), 64'd0);
    @(posedge clk);
    #1 rst = 0;
    build(MAGIC, 8'd5, COLS, 0, 1);
    run(0, 0, "good_row5_err");
    build(MAGIC, 8'd31, COLS, 0, 0);
    run(0, 0, "good_row31_err");
    build(8'h5A, 8'd0, 3, 0, 0);
    run(0, 0, "bad_magic_err");
    build(MAGIC, 8'd7, COLS, 0, 0);
    run(0, 0, "after_bad_magic_err");
    build(MAGIC, 8'd32, 2, 0, 0);
    run(0, 0, "bad_row_err");
    build(MAGIC, 8'd9, 10, 0, 0);
    run(0, 0, "short_err");
    pkt.delete();
    pkt.push_back(MAGIC);
    run(0, 0, "magic_tlast_err");
    build(MAGIC, 8'd12, COLS, 2, 0);
    run(0, 0, "long_err");
    drain();
    stall_at = cyc + 100;
    build(MAGIC, 8'd20, COLS, 0, 0);
    run(0, 0, "stall_err");
    drain();
    rmode = 1;
    for (int p = 0; p < 14; p++) begin
      int kind;
      kind = $urandom_range(7);
      case (kind)
        0, 1, 2: build(MAGIC, 8'($urandom_range(ROWS - 1)), COLS, 0, 0);
        3: build(MAGIC, 8'($urandom_range(ROWS - 1)), $urandom_range(COLS - 1), $urandom_range(2), 0);
        4: build(MAGIC, 8'($urandom_range(ROWS - 1)), COLS, $urandom_range(1, 3), 0);
        5: build(MAGIC, 8'($urandom_range(255, ROWS)), $urandom_range(3), 0, 0);
        6: build(MAGIC, 8'($urandom_range(ROWS - 1)), COLS, 0, 0);
        default: build(8'($urandom_range(8'hA4)), 8'($urandom), $urandom_range(3), 1, 0);
      endcase
      run(kind == 6, 1, "random_err");
    end
    drain();
    rmode = 0;
    build(MAGIC, 8'd3, 2, 0, 0);
    model(0);
    send_pkt(0, 0, 0);
    drain();
    rst = 1;
    @(posedge clk);
    #1 rst = 0;
    exp_err = 0;
    chk("midrst_err_clear", 64'(err_count), 64'd0);
    build(8'h11, 8'h22, 3, 0, 0);
    run(0, 0, "midrst_remainder_err");
    drain();
    s_axis_tdata = 8'h00;
    s_axis_tlast = 1;
    s_axis_tvalid = 1;
    repeat (65536) @(posedge clk);
    #1 s_axis_tvalid = 0;
    s_axis_tlast = 0;
    exp_err = 16'hFFFF;
    chk("err_saturate", 64'(err_count), 64'(exp_err));
    rmode = 1;
    build(MAGIC, 8'd31, COLS, 0, 0);
    run(1, 1, "tuser_sat_err");
    drain();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
